// File: rtl/syn_global_pkg.sv
// Shared SRAM bus constants and the bus-operation encoding used by the
// arbiter and by anything observing the SRAM access bus.
package syn_global_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_RD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        TURN = 2'd3
    } sram_bus_op_t;

endpackage

// File: rtl/syn_sram_rd_ret_pipe.sv
// Read-return tracker: RD_LAT-deep valid shift register plus capture of the
// driver's read data in the cycle before the valid strobe.
module syn_sram_rd_ret_pipe
    import syn_global_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W,
    parameter int RD_LAT = SRAM_RD_LAT
) (
    input  logic              clk_ir,
    input  logic              rst_sync,
    input  logic              issue,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data
);

    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT:0]   taps;

    // taps[k] is high k cycles after the bus read; taps[RD_LAT] is the strobe.
    assign taps          = {vld_sr, issue};
    assign rd_data_valid = taps[RD_LAT];

    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            vld_sr  <= '0;
            rd_data <= '0;
        end else begin
            vld_sr <= taps[RD_LAT-1:0];
            if (taps[RD_LAT-1]) begin
                rd_data <= sram_rd_data;
            end
        end
    end

endmodule

// File: rtl/syn_sram_acc_arb.sv
// SRAM access-bus initiator: arbitrates one write and one read client, inserts
// a read-to-write turnaround, and returns read data after the fixed latency.
module syn_sram_acc_arb
    import syn_global_pkg::*;
#(
    parameter int ADDR_W        = SRAM_ADDR_W,
    parameter int DATA_W        = SRAM_DATA_W,
    parameter int RD_LAT        = SRAM_RD_LAT,
    parameter int MAX_RD_STREAK = 8
) (
    input  logic              clk_ir,
    input  logic              rst_sync,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_be,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              sram_cs,
    output logic              sram_rd_en,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [1:0]        sram_be,
    output logic [DATA_W-1:0] sram_wr_data,
    input  logic [DATA_W-1:0] sram_rd_data
);

    localparam int                  STREAK_W   = $clog2(MAX_RD_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);

    sram_bus_op_t        op_next;
    logic                last_rd;
    logic                wr_force;
    logic                wr_force_next;
    logic                streak_clr;
    logic [STREAK_W-1:0] rd_streak;
    logic [STREAK_W-1:0] streak_next;

    // op_next is the bus operation for the following cycle; acks are its decode.
    always_comb begin
        op_next = IDLE;
        if (rst_sync) begin
            op_next = IDLE;
        end else if (rd_req && !wr_force) begin
            op_next = RD;
        end else if (wr_req && !last_rd) begin
            op_next = WR;
        end else if (last_rd) begin
            op_next = TURN;
        end
    end

    assign rd_ack = (op_next == RD);
    assign wr_ack = (op_next == WR);

    // A withdrawn write also releases the force so reads cannot deadlock.
    always_comb begin
        streak_clr  = wr_ack | ~wr_req;
        streak_next = rd_streak;
        if (streak_clr) begin
            streak_next = '0;
        end else if (rd_ack && (rd_streak != STREAK_MAX)) begin
            streak_next = rd_streak + 1'b1;
        end
        wr_force_next = ~streak_clr & (wr_force | (streak_next == STREAK_MAX));
    end

    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            last_rd      <= 1'b0;
            rd_streak    <= '0;
            wr_force     <= 1'b0;
            sram_cs      <= 1'b0;
            sram_rd_en   <= 1'b0;
            sram_wr_en   <= 1'b0;
            sram_addr    <= '0;
            sram_be      <= '0;
            sram_wr_data <= '0;
        end else begin
            last_rd    <= rd_ack;
            rd_streak  <= streak_next;
            wr_force   <= wr_force_next;
            sram_cs    <= rd_ack | wr_ack;
            sram_rd_en <= rd_ack;
            sram_wr_en <= wr_ack;
            if (rd_ack) begin
                sram_addr <= rd_addr;
                sram_be   <= 2'b11;
            end else if (wr_ack) begin
                sram_addr    <= wr_addr;
                sram_be      <= wr_be;
                sram_wr_data <= wr_data;
            end
        end
    end

    syn_sram_rd_ret_pipe #(
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) u_rd_ret (
        .clk_ir       (clk_ir),
        .rst_sync     (rst_sync),
        .issue        (sram_rd_en),
        .sram_rd_data (sram_rd_data),
        .rd_data_valid(rd_data_valid),
        .rd_data      (rd_data)
    );

endmodule

// File: tb/tb_syn_sram_acc_arb.sv
// Bench for syn_sram_acc_arb: directed scenarios plus random client traffic,
// checked cycle by cycle against a rule-level arbitration and memory model.
module tb_syn_sram_acc_arb;
    import syn_global_pkg::*;

    localparam int ADDR_W     = SRAM_ADDR_W;
    localparam int DATA_W     = SRAM_DATA_W;
    localparam int RD_LAT     = SRAM_RD_LAT;
    localparam int MAX_STREAK = 8;

    logic              clk_ir = 1'b0;
    logic              rst_sync = 1'b1;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [1:0]        wr_be = '0;
    logic              wr_ack;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_ack;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              sram_cs, sram_rd_en, sram_wr_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [1:0]        sram_be;
    logic [DATA_W-1:0] sram_wr_data;
    logic [DATA_W-1:0] sram_rd_data = '0;

    always #5 clk_ir = ~clk_ir;

    syn_sram_acc_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_RD_STREAK(MAX_STREAK)
    ) dut (
        .clk_ir(clk_ir), .rst_sync(rst_sync),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .sram_cs(sram_cs), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
        .sram_addr(sram_addr), .sram_be(sram_be), .sram_wr_data(sram_wr_data),
        .sram_rd_data(sram_rd_data)
    );

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } ret_t;

    ret_t              ret_q[$];
    logic [DATA_W-1:0] mem[logic [ADDR_W-1:0]];
    int                n_chk = 0, n_err = 0, cyc = 0;

    // Reference state: arbitration rules, expected bus for the current cycle,
    // and the read the emulated driver is answering this cycle.
    bit                m_last_rd = 0, m_force = 0;
    int                m_streak = 0;
    bit                m_bus_rd = 0, m_bus_wr = 0, m_prv_rd = 0;
    logic [ADDR_W-1:0] m_addr = '0, m_prv_addr = '0;
    logic [1:0]        m_be = '0;
    logic [DATA_W-1:0] m_wdata = '0, m_rd_data = '0;
    bit                e_rd_ack = 0, e_wr_ack = 0, e_valid;
    bit                o_rd_ack, o_wr_ack, o_valid;

    function automatic logic [DATA_W-1:0] rdmem(input logic [ADDR_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ {a[17:16], 14'h1A5B};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: inputs already driven at posedge+1; compare at posedge+2.
    task automatic cyc_step();
        ret_t r;
        sram_rd_data = m_prv_rd ? rdmem(m_prv_addr) : DATA_W'($urandom);
        #1;
        e_rd_ack = rd_req && !m_force && !rst_sync;
        e_wr_ack = !e_rd_ack && wr_req && !m_last_rd && !rst_sync;
        e_valid  = (ret_q.size() > 0) && (ret_q[0].due == cyc);
        o_rd_ack = rd_ack;
        o_wr_ack = wr_ack;
        o_valid  = rd_data_valid;
        check("rd_ack", rd_ack, e_rd_ack);
        check("wr_ack", wr_ack, e_wr_ack);
        check("sram_cs", sram_cs, m_bus_rd | m_bus_wr);
        check("sram_rd_en", sram_rd_en, m_bus_rd);
        check("sram_wr_en", sram_wr_en, m_bus_wr);
        check("sram_addr", sram_addr, m_addr);
        check("sram_be", sram_be, m_be);
        check("sram_wr_data", sram_wr_data, m_wdata);
        check("rd_data_valid", rd_data_valid, e_valid);
        if (e_valid) begin
            m_rd_data = ret_q[0].data;
            void'(ret_q.pop_front());
        end
        check("rd_data", rd_data, m_rd_data);
        @(posedge clk_ir);
        if (rst_sync) begin
            ret_q.delete();
            {m_last_rd, m_force, m_bus_rd, m_bus_wr, m_prv_rd} = '0;
            m_streak = 0;
            m_addr = '0; m_prv_addr = '0; m_be = '0; m_wdata = '0; m_rd_data = '0;
        end else begin
            m_prv_rd   = m_bus_rd;
            m_prv_addr = m_addr;
            m_bus_rd   = e_rd_ack;
            m_bus_wr   = e_wr_ack;
            if (e_rd_ack) begin
                m_addr = rd_addr;
                m_be   = 2'b11;
                r.due  = cyc + 1 + RD_LAT;
                r.data = rdmem(rd_addr);
                ret_q.push_back(r);
            end
            if (e_wr_ack) begin
                m_addr = wr_addr; m_be = wr_be; m_wdata = wr_data;
            end
            m_last_rd = e_rd_ack;
            if (e_wr_ack || !wr_req) begin
                m_streak = 0;
                m_force  = 0;
            end else if (e_rd_ack) begin
                if (m_streak < MAX_STREAK) m_streak++;
                if (m_streak == MAX_STREAK) m_force = 1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        rd_req = 1'b0;
        wr_req = 1'b0;
        repeat (n) cyc_step();
    endtask

    initial begin
        int nrd, ngap, nv, first_v, last_v;
        bit wr_seen, withdrawn;

        @(posedge clk_ir);
        #1;
        cyc_step();
        rst_sync = 1'b0;
        idle(2);

        // Single read returning BEEF.
        mem[18'h000A5] = 16'hBEEF;
        rd_req = 1'b1; rd_addr = 18'h000A5;
        cyc_step();
        check("single_rd_ack", o_rd_ack, 1);
        idle(5);

        // Single write at the top address, low byte only.
        wr_req = 1'b1; wr_addr = 18'h3FFFF; wr_data = 16'h1234; wr_be = 2'b01;
        cyc_step();
        check("single_wr_ack", o_wr_ack, 1);
        idle(4);

        // Read immediately followed by a write request: turnaround cycle.
        rd_req = 1'b1; rd_addr = 18'h00123;
        cyc_step();
        rd_req = 1'b0; wr_req = 1'b1; wr_addr = 18'h00456; wr_data = 16'hA5A5; wr_be = 2'b11;
        cyc_step();
        check("turn_no_ack", o_wr_ack, 0);
        cyc_step();
        check("turn_wr_ack", o_wr_ack, 1);
        idle(5);

        // Continuous reads against a pending write: starvation guard.
        rd_req = 1'b1; rd_addr = 18'd100;
        wr_req = 1'b1; wr_addr = 18'h2_0000; wr_data = 16'h0F0F; wr_be = 2'b10;
        nrd = 0; ngap = 0; wr_seen = 0;
        for (int i = 0; i < 30 && !wr_seen; i++) begin
            cyc_step();
            if (o_wr_ack) wr_seen = 1;
            else if (o_rd_ack) begin nrd++; rd_addr = rd_addr + 1'b1; end
            else ngap++;
        end
        wr_req = 1'b0;
        check("streak_wr_seen", wr_seen, 1);
        check("streak_reads", nrd, MAX_STREAK);
        check("streak_gap", ngap, 1);
        cyc_step();
        check("streak_resume", o_rd_ack, 1);
        idle(6);

        // Four back-to-back reads, addresses 0..3.
        nv = 0; first_v = -1; last_v = -1;
        for (int k = 0; k < 10; k++) begin
            rd_req = (k < 4);
            rd_addr = ADDR_W'(k);
            cyc_step();
            if (o_valid) begin
                nv++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
        end
        check("b2b_valid_cnt", nv, 4);
        check("b2b_span", last_v - first_v, 3);

        // Reset one cycle after a read's bus cycle discards the return.
        rd_req = 1'b1; rd_addr = 18'h00077;
        cyc_step();
        rd_req = 1'b0;
        cyc_step();
        rst_sync = 1'b1;
        cyc_step();
        rst_sync = 1'b0;
        check("rst_bus_cs", sram_cs, 0);
        nv = 0;
        for (int k = 0; k < 5; k++) begin
            cyc_step();
            if (o_valid) nv++;
        end
        check("rst_no_valid", nv, 0);

        // Random client traffic with read-heavy phases and rare resets.
        for (int i = 0; i < 4000; i++) begin
            rst_sync = ($urandom_range(0, 599) == 0);
            if (e_rd_ack) rd_req = 1'b0;
            if (e_wr_ack) wr_req = 1'b0;
            withdrawn = 0;
            if (rd_req && $urandom_range(0, 19) == 0) begin
                rd_req = 1'b0;
                withdrawn = 1;
            end
            if (!rd_req && !withdrawn && $urandom_range(0, 9) < (((i / 500) % 2 == 1) ? 10 : 4)) begin
                rd_req = 1'b1;
                rd_addr = ADDR_W'($urandom);
            end
            if (!wr_req && $urandom_range(0, 9) < 3) begin
                wr_req = 1'b1;
                wr_addr = ADDR_W'($urandom);
                wr_data = DATA_W'($urandom);
                wr_be = 2'($urandom_range(1, 3));
            end
            cyc_step();
        end
        rst_sync = 1'b0;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
